// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM encodings
// and the constants of the shift-add-3 digit correction.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_e;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD       = 4'd3;

endpackage : bcd_pkg

// File: rtl/bin_to_bcd_sequential_if.sv
// Level start/done handshake plus data buses between the producer stage
// (pop-count or bench) and the BCD converter.
interface bin_to_bcd_sequential_if
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);

    logic                          start;
    logic [WIDTH-1:0]              bin_in;
    logic [DIGITS*BCD_DIGIT_W-1:0] bcd_out;
    logic                          done;

    modport master (
        output start,
        output bin_in,
        input  bcd_out,
        input  done
    );

    modport slave (
        input  start,
        input  bin_in,
        output bcd_out,
        output done
    );

endinterface : bin_to_bcd_sequential_if

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next digit.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    // 4-bit add with no carry out: a digit <= 9 stays <= 12 after correction
    always_comb begin
        if (digit_in >= ADJ_THRESHOLD) begin
            digit_out = digit_in + ADJ_ADD;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule : bcd_digit_adjust

// File: rtl/bin_to_bcd_sequential.sv
// Sequential double-dabble converter: one shift-add-3 iteration per clock,
// WIDTH iterations per conversion, result held in bcd_out until the next one.
module bin_to_bcd_sequential
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
)
(
    input  logic                   clk,
    input  logic                   rst,
    bin_to_bcd_sequential_if.slave bus
);

    localparam int BCD_W  = DIGITS * BCD_DIGIT_W;
    localparam int TOT_W  = BCD_W + WIDTH;
    localparam int ITER_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH - 1);

    if ((10 ** DIGITS) < (2 ** WIDTH)) begin : g_digits_check
        $error("bin_to_bcd_sequential: DIGITS too small to hold 2**WIDTH-1");
    end

    bcd_state_e        state_r;
    bcd_state_e        state_next_s;
    logic [TOT_W-1:0]  shift_r;
    logic [TOT_W-1:0]  adjusted_s;
    logic [TOT_W-1:0]  shifted_s;
    logic [ITER_W-1:0] iter_r;
    logic [BCD_W-1:0]  bcd_r;
    logic              done_r;
    logic              load_s;
    logic              shift_en_s;
    logic              finish_s;

    // Correct every BCD digit of the scratch register; binary part passes through
    for (genvar d = 0; d < DIGITS; d++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .digit_in  (shift_r[WIDTH + d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (adjusted_s[WIDTH + d*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end
    assign adjusted_s[WIDTH-1:0] = shift_r[WIDTH-1:0];
    assign shifted_s             = adjusted_s << 1'b1;

    // Next-state and datapath control decode
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        shift_en_s   = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_START: begin
                if (bus.start) begin
                    state_next_s = ST_SHIFT;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_SHIFT: begin
                shift_en_s = 1'b1;
                if (iter_r == ITER_LAST) begin
                    state_next_s = ST_DONE;
                    finish_s     = 1'b1;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // start must be seen low once before another conversion
                if (bus.start) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_START;
                end
            end
            default: begin
                state_next_s = ST_START;
            end
        endcase
    end

    // State, scratch register, iteration counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_START;
            shift_r <= {TOT_W{1'b0}};
            iter_r  <= {ITER_W{1'b0}};
            bcd_r   <= {BCD_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            done_r  <= (state_next_s == ST_DONE);
            if (load_s) begin
                shift_r <= {{BCD_W{1'b0}}, bus.bin_in};
                iter_r  <= {ITER_W{1'b0}};
            end else if (shift_en_s) begin
                shift_r <= shifted_s;
                iter_r  <= iter_r + 1'b1;
            end
            if (finish_s) begin
                bcd_r <= shifted_s[TOT_W-1 -: BCD_W];
            end
        end
    end

    assign bus.bcd_out = bcd_r;
    assign bus.done    = done_r;

endmodule : bin_to_bcd_sequential
